data_mem_unit: RTL and testbench
================================

Name: data_mem_unit

Overview:
- Parametrised successor to the flat 64-bit data memory.
- Byte-addressed and size-aware (byte/half/word/dword) with sign/zero extension on loads and lane-merged stores.
- Valid/ready request handshake, fixed configurable response latency, and an error response for misaligned or out-of-range accesses.
- Sits between the MEM stage and the data array; one request outstanding at a time.

Parameters:
DEPTH, 1024, number of N-bit words in the array
ADDR_W, 10, log2(DEPTH)
N, 64, word and data width in bits; legal values are 32 and 64
LATENCY, 2, cycles from the accepting edge to resp_valid; legal range 1..15

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request this cycle
req_write  in  1  1 = store, 0 = load
req_addr  in  N  byte address
req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword
req_signed  in  1  load: sign-extend (1) or zero-extend (0); ignored on stores
req_wdata  in  N  store data, right-justified
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  N  load result; 0 on stores, on errors and when resp_valid = 0
resp_err  out  1  qualifies resp_valid; access was rejected

Behaviour:
- Definitions:
  - OFS = log2(N/8); word index = req_addr[ADDR_W+OFS-1:OFS]; lane = req_addr[OFS-1:0].
  - Access bytes = 2^req_size.
- Error conditions, evaluated at acceptance:
  - Misaligned: lane not a multiple of the access bytes.
  - Out of range: req_addr[N-1:ADDR_W+OFS] nonzero.
  - Oversize: req_size = 3 with N = 32.
- Error effects: no array write, resp_err = 1, resp_rdata = 0.
- FSM states: IDLE, WAIT, RESP.
  - req_ready = 1 only in IDLE.
  - IDLE: accept when req_valid & req_ready; go to WAIT (LATENCY > 1) or RESP (LATENCY = 1). Counter loads LATENCY-1.
  - WAIT: decrement the counter each cycle; go to RESP when the counter reaches 1.
  - RESP: resp_valid = 1 for exactly one cycle, then IDLE.
- Timing: resp_valid rises LATENCY cycles after the accepting edge. Throughput is one request per LATENCY+1 cycles.
- Requests while not ready are ignored. The master must hold req_valid and its payload until accepted.
- Store:
  - Commits at the accepting edge.
  - Only the addressed bytes change: bytes lane..lane+size-1 take req_wdata[8*size-1:0]. All other bytes of the word are unchanged.
- Load:
  - The array word is sampled at the accepting edge and held internally until RESP.
  - Result = (word >> 8*lane), truncated to 8*size bits, then extended to N bits using bit 8*size-1 if req_signed, else zeros.
  - Dword loads, and word loads with N = 32, pass through unchanged.
- Output registers:
  - resp_rdata and resp_err are registered and driven only in RESP; 0 otherwise.
  - No tri-state outputs; resp_rdata is never X/Z after reset.
- Reset:
  - State := IDLE, counter := 0, req_ready = 1 in the cycle after the reset edge, resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - The array contents are not cleared.
- Reset mid-operation:
  - A pending response is dropped (no resp_valid).
  - A store accepted before reset stays committed.
- A request presented in the reset cycle is not accepted.

Test Plan:
- Store dword 0x1122334455667788 at addr 0x40, then load dword at 0x40 -> resp_valid exactly LATENCY (2) cycles after each accept; rdata = 0x1122334455667788; resp_err = 0; req_ready low for 2 cycles after each accept.
- With the above word in memory, store byte 0xAB at 0x43, then load dword 0x40 -> 0x11223344AB667788. Signed byte load 0x43 -> 0xFFFFFFFFFFFFFFAB; unsigned -> 0x00000000000000AB; signed half load at 0x46 -> 0x0000000000001122.
- Misaligned word store at 0x42 with wdata 0xDEADBEEF -> resp_err = 1, rdata = 0; a following dword load at 0x40 is unchanged (0x11223344AB667788).
- Load at 0x2000 (DEPTH = 1024, N = 64, first out-of-range byte address) -> resp_err = 1; store to 0x2000 leaves word 0 unchanged.
- Hold req_valid high with back-to-back loads to 0x0, 0x8, 0x10 -> accepts spaced exactly 3 cycles apart (LATENCY + 1); responses return in order; no request dropped or duplicated.
- Store 0x5 to 0x80, assert rst 1 cycle later (during WAIT) -> no resp_valid; req_ready = 1 in the cycle after the reset edge; a subsequent load at 0x80 returns 0x5.

Source files
------------

// File: rtl/data_mem_unit.sv
// rtl/data_mem_unit.sv - byte-addressed, size-aware data memory with valid/ready request and fixed-latency response
// Loads sign/zero-extend the addressed lanes, stores merge bytes; misaligned or out-of-range accesses return an error.
module data_mem_unit #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int N       = 64,
  parameter int LATENCY = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic         i_req_write,
  input  logic [N-1:0] i_req_addr,
  input  logic [1:0]   i_req_size,
  input  logic         i_req_signed,
  input  logic [N-1:0] i_req_wdata,
  output logic         o_resp_valid,
  output logic [N-1:0] o_resp_rdata,
  output logic         o_resp_err
);

  localparam int OFS   = $clog2(N / 8);
  localparam int BYTES = N / 8;
  localparam int IDX_W = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t       r_state, w_state_n;
  logic [3:0]   r_cnt, w_cnt_n;
  logic [N-1:0] r_mem [DEPTH];
  logic [N-1:0] r_rdata;
  logic         r_err;

  logic [ADDR_W-1:0] w_idx;
  logic [OFS-1:0]    w_lane;
  logic [3:0]        w_nbytes;
  logic [7:0]        w_nbits;
  logic              w_misalign, w_oor, w_oversize, w_err, w_accept;
  logic [N-1:0]      w_word, w_sh, w_mask, w_load, w_wsh;
  logic              w_sign;
  logic [BYTES-1:0]  w_be;

  assign w_idx      = i_req_addr[ADDR_W+OFS-1:OFS];
  assign w_lane     = i_req_addr[OFS-1:0];
  assign w_nbytes   = 4'd1 << i_req_size;
  assign w_nbits    = 8'd8 << i_req_size;
  assign w_misalign = (w_lane & OFS'(w_nbytes - 4'd1)) != '0;
  assign w_oor      = (i_req_addr >> (ADDR_W + OFS)) != '0;
  assign w_oversize = (N == 32) && (i_req_size == 2'd3);
  assign w_err      = w_misalign || w_oor || w_oversize;
  assign w_accept   = i_req_valid && (r_state == S_IDLE);

  // Load path: shift the addressed lanes down, then mask and extend to the access width.
  always_comb begin
    w_word = r_mem[w_idx];
    w_sh   = w_word >> {w_lane, 3'b000};
    w_mask = ~({N{1'b1}} << w_nbits);
    w_sign = i_req_signed && w_sh[IDX_W'(w_nbits - 8'd1)];
    w_load = w_sh;
    if (w_nbits < 8'(N)) begin
      w_load = (w_sh & w_mask) | (w_sign ? ~w_mask : '0);
    end
  end

  assign w_be  = ~({BYTES{1'b1}} << w_nbytes) << w_lane;
  assign w_wsh = i_req_wdata << {w_lane, 3'b000};

  // Array is never cleared; a store commits on its accepting edge only.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_accept && i_req_write && !w_err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wsh[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_n   = 4'(LATENCY - 1);
          w_state_n = (LATENCY > 1) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        w_cnt_n = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_state_n = S_RESP;
      end
      S_RESP:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      if (w_accept) begin
        r_err   <= w_err;
        r_rdata <= (w_err || i_req_write) ? '0 : w_load;
      end
    end
  end

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_resp_valid = (r_state == S_RESP);
  assign o_resp_rdata = o_resp_valid ? r_rdata : '0;
  assign o_resp_err   = o_resp_valid && r_err;

endmodule

// File: tb/tb_data_mem_unit.sv
// tb/tb_data_mem_unit.sv - directed self-checking bench for data_mem_unit (N=64, LATENCY=2)
module tb_data_mem_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_write;
  logic [63:0] i_req_addr;
  logic [1:0]  i_req_size;
  logic        i_req_signed;
  logic [63:0] i_req_wdata;
  logic        o_resp_valid;
  logic [63:0] o_resp_rdata;
  logic        o_resp_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  data_mem_unit #(.DEPTH(1024), .ADDR_W(10), .N(64), .LATENCY(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_addr(i_req_addr),
    .i_req_size(i_req_size), .i_req_signed(i_req_signed),
    .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic do_req(input logic w, input logic [63:0] a, input logic [1:0] sz, input logic sg,
                        input logic [63:0] wd, output logic [63:0] rd, output logic e,
                        output int lat, output int rdy_low, output bit pulse1);
    int  g;
    bit  got;
    i_req_write = w; i_req_addr = a; i_req_size = sz; i_req_signed = sg; i_req_wdata = wd;
    i_req_valid = 1'b1;
    g = 0;
    while (!o_req_ready && g < 20) begin @(negedge i_clk); g++; end
    @(posedge i_clk);
    lat = 0; rdy_low = 0; got = 0; rd = '1; e = 1'b1;
    while (!got && lat < 20) begin
      @(negedge i_clk);
      i_req_valid = 1'b0;
      lat++;
      if (!o_req_ready) rdy_low++;
      if (o_resp_valid) begin got = 1; rd = o_resp_rdata; e = o_resp_err; end
    end
    @(negedge i_clk);
    pulse1 = got && !o_resp_valid;
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_req_valid = 1'b0; i_req_write = 1'b0; i_req_addr = '0;
    i_req_size = 2'd0; i_req_signed = 1'b0; i_req_wdata = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_req_ready); end
    total++; if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_resp_valid); end
    total++; if (o_resp_rdata !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", o_resp_rdata); end
    total++; if (o_resp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", o_resp_err); end
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_dword;
    logic [63:0] rd; logic e; int lat, rl; bit p1;
    do_req(1'b1, 64'h40, 2'd3, 1'b0, 64'h1122334455667788, rd, e, lat, rl, p1);
    total++; if (lat !== 2) begin bad++; $display("FAIL st_latency got=%0d exp=2", lat); end
    total++; if (rl !== 2) begin bad++; $display("FAIL st_ready_low got=%0d exp=2", rl); end
    total++; if (e !== 1'b0 || rd !== 64'h0) begin bad++; $display("FAIL st_resp got=%b/%h exp=0/0", e, rd); end
    total++; if (!p1) begin bad++; $display("FAIL st_pulse got=%b exp=1", p1); end
    do_req(1'b0, 64'h40, 2'd3, 1'b0, 64'h0, rd, e, lat, rl, p1);
    total++; if (lat !== 2) begin bad++; $display("FAIL ld_latency got=%0d exp=2", lat); end
    total++; if (rl !== 2) begin bad++; $display("FAIL ld_ready_low got=%0d exp=2", rl); end
    total++; if (rd !== 64'h1122334455667788 || e !== 1'b0) begin bad++; $display("FAIL ld_dword got=%h/%b exp=1122334455667788/0", rd, e); end
    total++; if (!p1) begin bad++; $display("FAIL ld_pulse got=%b exp=1", p1); end
  endtask

  task automatic test_byte_lanes;
    logic [63:0] rd; logic e; int lat, rl; bit p1;
    do_req(1'b1, 64'h43, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFAB, rd, e, lat, rl, p1);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL stb_err got=%b exp=0", e); end
    do_req(1'b0, 64'h40, 2'd3, 1'b0, 64'h0, rd, e, lat, rl, p1);
    total++; if (rd !== 64'h11223344AB667788) begin bad++; $display("FAIL merge got=%h exp=11223344ab667788", rd); end
    do_req(1'b0, 64'h43, 2'd0, 1'b1, 64'h0, rd, e, lat, rl, p1);
    total++; if (rd !== 64'hFFFFFFFFFFFFFFAB) begin bad++; $display("FAIL ldb_signed got=%h exp=ffffffffffffffab", rd); end
    do_req(1'b0, 64'h43, 2'd0, 1'b0, 64'h0, rd, e, lat, rl, p1);
    total++; if (rd !== 64'h00000000000000AB) begin bad++; $display("FAIL ldb_unsigned got=%h exp=ab", rd); end
    do_req(1'b0, 64'h46, 2'd1, 1'b1, 64'h0, rd, e, lat, rl, p1);
    total++; if (rd !== 64'h0000000000001122) begin bad++; $display("FAIL ldh_signed got=%h exp=1122", rd); end
    do_req(1'b0, 64'h44, 2'd1, 1'b0, 64'h0, rd, e, lat, rl, p1);
    total++; if (rd !== 64'h0000000000003344) begin bad++; $display("FAIL ldh_unsigned got=%h exp=3344", rd); end
    do_req(1'b0, 64'h40, 2'd2, 1'b1, 64'h0, rd, e, lat, rl, p1);
    total++; if (rd !== 64'hFFFFFFFFAB667788) begin bad++; $display("FAIL ldw_signed got=%h exp=ffffffffab667788", rd); end
    do_req(1'b0, 64'h40, 2'd2, 1'b0, 64'h0, rd, e, lat, rl, p1);
    total++; if (rd !== 64'h00000000AB667788) begin bad++; $display("FAIL ldw_unsigned got=%h exp=ab667788", rd); end
  endtask

  task automatic test_misaligned;
    logic [63:0] rd; logic e; int lat, rl; bit p1;
    do_req(1'b1, 64'h42, 2'd2, 1'b0, 64'hDEADBEEF, rd, e, lat, rl, p1);
    total++; if (e !== 1'b1 || rd !== 64'h0) begin bad++; $display("FAIL mis_st got=%b/%h exp=1/0", e, rd); end
    total++; if (lat !== 2) begin bad++; $display("FAIL mis_latency got=%0d exp=2", lat); end
    do_req(1'b0, 64'h40, 2'd3, 1'b0, 64'h0, rd, e, lat, rl, p1);
    total++; if (rd !== 64'h11223344AB667788 || e !== 1'b0) begin bad++; $display("FAIL mis_keep got=%h/%b exp=11223344ab667788/0", rd, e); end
    do_req(1'b0, 64'h41, 2'd1, 1'b1, 64'h0, rd, e, lat, rl, p1);
    total++; if (e !== 1'b1 || rd !== 64'h0) begin bad++; $display("FAIL mis_ldh got=%b/%h exp=1/0", e, rd); end
  endtask

  task automatic test_range;
    logic [63:0] rd; logic e; int lat, rl; bit p1;
    do_req(1'b1, 64'h0, 2'd3, 1'b0, 64'hA0A1A2A3A4A5A6A7, rd, e, lat, rl, p1);
    do_req(1'b0, 64'h2000, 2'd3, 1'b0, 64'h0, rd, e, lat, rl, p1);
    total++; if (e !== 1'b1 || rd !== 64'h0) begin bad++; $display("FAIL oor_ld got=%b/%h exp=1/0", e, rd); end
    do_req(1'b1, 64'h2000, 2'd3, 1'b0, 64'h5555AAAA5555AAAA, rd, e, lat, rl, p1);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_st got=%b exp=1", e); end
    do_req(1'b0, 64'h0, 2'd3, 1'b0, 64'h0, rd, e, lat, rl, p1);
    total++; if (rd !== 64'hA0A1A2A3A4A5A6A7 || e !== 1'b0) begin bad++; $display("FAIL oor_keep got=%h/%b exp=a0a1a2a3a4a5a6a7/0", rd, e); end
    do_req(1'b0, 64'h1FF8, 2'd3, 1'b0, 64'h0, rd, e, lat, rl, p1);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL last_word_err got=%b exp=0", e); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] rd; logic e; int lat, rl; bit p1;
    logic [63:0] addrs [3];
    logic [63:0] exps  [3];
    int acc [3];
    int g;
    bit extra;
    addrs[0] = 64'h0;  exps[0] = 64'hA0A1A2A3A4A5A6A7;
    addrs[1] = 64'h8;  exps[1] = 64'hB0B1B2B3B4B5B6B7;
    addrs[2] = 64'h10; exps[2] = 64'hC0C1C2C3C4C5C6C7;
    do_req(1'b1, addrs[1], 2'd3, 1'b0, exps[1], rd, e, lat, rl, p1);
    do_req(1'b1, addrs[2], 2'd3, 1'b0, exps[2], rd, e, lat, rl, p1);
    i_req_write = 1'b0; i_req_size = 2'd3; i_req_signed = 1'b0; i_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_req_addr = addrs[i];
      g = 0;
      while (!o_req_ready && g < 20) begin @(negedge i_clk); g++; end
      acc[i] = cyc;
      g = 0;
      do begin @(negedge i_clk); g++; end while (!o_resp_valid && g < 20);
      total++; if (o_resp_rdata !== exps[i] || o_resp_err !== 1'b0) begin
        bad++; $display("FAIL b2b_data%0d got=%h exp=%h", i, o_resp_rdata, exps[i]);
      end
    end
    i_req_valid = 1'b0;
    total++; if (acc[1] - acc[0] !== 3) begin bad++; $display("FAIL b2b_gap01 got=%0d exp=3", acc[1] - acc[0]); end
    total++; if (acc[2] - acc[1] !== 3) begin bad++; $display("FAIL b2b_gap12 got=%0d exp=3", acc[2] - acc[1]); end
    extra = 0;
    repeat (6) begin @(negedge i_clk); if (o_resp_valid) extra = 1; end
    total++; if (extra) begin bad++; $display("FAIL b2b_extra got=1 exp=0"); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] rd; logic e; int lat, rl; bit p1;
    bit seen;
    i_req_write = 1'b1; i_req_addr = 64'h80; i_req_size = 2'd3; i_req_signed = 1'b0;
    i_req_wdata = 64'h5; i_req_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", o_req_ready); end
    seen = o_resp_valid;
    i_rst = 1'b0;
    repeat (4) begin @(negedge i_clk); if (o_resp_valid) seen = 1; end
    total++; if (seen) begin bad++; $display("FAIL rstmid_drop got=1 exp=0"); end
    do_req(1'b0, 64'h80, 2'd3, 1'b0, 64'h0, rd, e, lat, rl, p1);
    total++; if (rd !== 64'h5 || e !== 1'b0) begin bad++; $display("FAIL rstmid_commit got=%h/%b exp=5/0", rd, e); end
  endtask

  initial begin
    test_reset;
    test_dword;
    test_byte_lanes;
    test_misaligned;
    test_range;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
